pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  synchronous, active-low reset; sampled on rising clk; rst==0 resets.
REQ-003 if_req  in  1  IF waiting on instruction memory.
REQ-004 mm_req  in  1  MEM access pending (load/store not complete).
REQ-005 id_re1, id_re2  in  1 each  decode reads rs1/rs2.
REQ-006 id_ra1, id_ra2  in  5 each  decode source register addresses.
REQ-007 ex_ld  in  1  instruction in EX is a load.
REQ-008 ex_wa  in  5  EX destination register.
REQ-009 br_take  in  1  EX resolved a taken branch/JAL/JALR.
REQ-010 br_pc  in  32  redirect target.
REQ-011 stall  out  6  hold per stage; bit0 pc, 1 if, 2 id, 3 ex, 4 mm, 5 wb.
REQ-012 flush  out  1  load NOP into IF/ID and ID/EX.
REQ-013 pc_we  out  1  force PC load.
REQ-014 pc_nxt  out  32  value for PC when pc_we=1.
REQ-015 state  out  2  FSM state, debug.
REQ-016 stall_cnt  out  32  stalled-cycle count (only when PERF_CNT_EN is defined).

Function
REQ-017 FSM states: RUN=0, LDUSE=1, MEMW=2, REDIR=3; state output = registered state.
REQ-018 All outputs except state and stall_cnt are combinational from the registered state, pend_v/pend_pc and current inputs.
REQ-019 Priority per cycle: mm_req > pending redirect > br_take > load-use > if_req.
REQ-020 mm_req=1: stall=6'b011111, flush=0, pc_we=0; next state MEMW; remain MEMW while mm_req=1.
REQ-021 br_take=1 with mm_req=1: latch br_pc into pend_pc, set pend_v=1; a later br_take during the same MEMW overwrites pend_pc.
REQ-022 First cycle with mm_req=0 and pend_v=1: pc_we=1, pc_nxt=pend_pc, flush=1, stall=0; clear pend_v; next state REDIR.
REQ-023 br_take=1, mm_req=0, pend_v=0: pc_we=1, pc_nxt=br_pc, flush=1, stall=0 in the same cycle; next state REDIR.
REQ-024 REDIR lasts exactly one cycle: flush=1, pc_we=0, if_req ignored (stall=0); next state RUN unless a higher-priority condition applies.
REQ-025 Load-use hazard = ex_ld & ex_wa!=0 & ((id_re1 & id_ra1==ex_wa) | (id_re2 & id_ra2==ex_wa)).
REQ-026 Load-use with no higher-priority condition: stall=6'b000111, flush=0 for exactly that cycle; next state LDUSE.
REQ-027 In LDUSE, hazard detection is re-evaluated normally; EX holds a bubble, so a single load yields exactly one stall cycle.
REQ-028 if_req only: stall=6'b000011; IF/ID inserts a NOP whenever stall[1]=1 and stall[2]=0.
REQ-029 No condition active: stall=0, flush=0, pc_we=0, pc_nxt=0; next state RUN.
REQ-030 ex_wa==0 never produces a hazard (x0).

Reset
REQ-031 rst=0 at a clock edge: state=RUN, pend_v=0, pend_pc=0, stall_cnt=0.
REQ-032 While rst=0: stall=0, flush=0, pc_we=0, pc_nxt=0 regardless of inputs.
REQ-033 Reset in any state, including MEMW with pend_v=1, discards the pending redirect.

Configuration
REQ-034 Macro PIPE_CTRL_PERF_CNT_EN defined: stall_cnt increments by 1 (wrapping at 2^32) each cycle with stall[0]=1 and rst=1.
REQ-035 Macro undefined: stall_cnt port and counter absent; all other behaviour identical.

Verification
REQ-036 ex_ld=1, ex_wa=5, id_re1=1, id_ra1=5 for one cycle -> stall=000111 that cycle; state=LDUSE next; stall=0 after.
REQ-037 ex_ld=1, ex_wa=0, id_ra1=0, id_re1=1 -> stall=0, state stays RUN.
REQ-038 br_take=1, br_pc=0x00001000 in RUN -> same cycle pc_we=1, pc_nxt=0x1000, flush=1; next cycle REDIR with flush=1, pc_we=0; then RUN.
REQ-039 mm_req=1 for 3 cycles, br_take=1 with br_pc=0x200 in cycle 2 -> stall=011111 for 3 cycles, pc_we=0; cycle 4: pc_we=1, pc_nxt=0x200, flush=1.
REQ-040 mm_req=1 with pend_v=1, rst=0 one cycle, then mm_req=0 -> state=RUN, no pc_we pulse.
REQ-041 PIPE_CTRL_PERF_CNT_EN defined, 4 mm_req cycles + 1 load-use cycle -> stall_cnt=5.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/redirect controller: stalls, flushes and PC redirects for a 5-stage core.
// Optional macro PIPE_CTRL_PERF_CNT_EN adds the stall_cnt stalled-cycle counter port.
module pipe_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic        mm_req,
  input  logic        id_re1,
  input  logic        id_re2,
  input  logic [4:0]  id_ra1,
  input  logic [4:0]  id_ra2,
  input  logic        ex_ld,
  input  logic [4:0]  ex_wa,
  input  logic        br_take,
  input  logic [31:0] br_pc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic        pc_we,
  output logic [31:0] pc_nxt,
  output logic [1:0]  state
`ifdef PIPE_CTRL_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_LDUSE = 2'd1,
    ST_MEMW  = 2'd2,
    ST_REDIR = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic        pend_v_r;
  logic        pend_v_nxt_s;
  logic [31:0] pend_pc_r;
  logic [31:0] pend_pc_nxt_s;
  logic        hazard_s;

  // x0 is never a real destination, so it can never create a dependency.
  function automatic logic load_use_hazard(
    input logic       ld,
    input logic [4:0] wa,
    input logic       re1,
    input logic [4:0] ra1,
    input logic       re2,
    input logic [4:0] ra2
  );
    load_use_hazard = ld & (wa != 5'd0) &
                      ((re1 & (ra1 == wa)) | (re2 & (ra2 == wa)));
  endfunction

  assign hazard_s = load_use_hazard(ex_ld, ex_wa, id_re1, id_ra1, id_re2, id_ra2);
  assign state    = state_r;

  // Priority resolution: next state, pending redirect and per-cycle control outputs.
  always_comb begin
    stall         = 6'b000000;
    flush         = 1'b0;
    pc_we         = 1'b0;
    pc_nxt        = 32'h0000_0000;
    state_nxt_s   = ST_RUN;
    pend_v_nxt_s  = pend_v_r;
    pend_pc_nxt_s = pend_pc_r;
    if (!rst) begin
      state_nxt_s   = ST_RUN;
      pend_v_nxt_s  = 1'b0;
      pend_pc_nxt_s = 32'h0000_0000;
    end else if (mm_req) begin
      stall       = 6'b011111;
      state_nxt_s = ST_MEMW;
      // A branch resolved while memory holds the pipe is remembered; the latest one wins.
      if (br_take) begin
        pend_v_nxt_s  = 1'b1;
        pend_pc_nxt_s = br_pc;
      end else begin
        pend_v_nxt_s  = pend_v_r;
        pend_pc_nxt_s = pend_pc_r;
      end
    end else if (pend_v_r) begin
      pc_we        = 1'b1;
      pc_nxt       = pend_pc_r;
      flush        = 1'b1;
      pend_v_nxt_s = 1'b0;
      state_nxt_s  = ST_REDIR;
    end else if (br_take) begin
      pc_we       = 1'b1;
      pc_nxt      = br_pc;
      flush       = 1'b1;
      state_nxt_s = ST_REDIR;
    end else if (state_r == ST_REDIR) begin
      // Second flush cycle squashes the wrong-path fetch; IF and decode state are don't-care.
      flush       = 1'b1;
      state_nxt_s = ST_RUN;
    end else if (hazard_s) begin
      stall       = 6'b000111;
      state_nxt_s = ST_LDUSE;
    end else if (if_req) begin
      stall       = 6'b000011;
      state_nxt_s = ST_RUN;
    end else begin
      state_nxt_s = ST_RUN;
    end
  end

  // State and pending-redirect registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r   <= ST_RUN;
      pend_v_r  <= 1'b0;
      pend_pc_r <= 32'h0000_0000;
    end else begin
      state_r   <= state_nxt_s;
      pend_v_r  <= pend_v_nxt_s;
      pend_pc_r <= pend_pc_nxt_s;
    end
  end

`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [31:0] stall_cnt_r;

  // Counts cycles in which the PC is held; wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_r <= 32'h0000_0000;
    end else if (stall[0]) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios then randomized traffic
// against a priority-rule reference model.
module tb_pipe_ctrl;

  localparam int S_RUN   = 0;
  localparam int S_LDUSE = 1;
  localparam int S_MEMW  = 2;
  localparam int S_REDIR = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, mm_req, id_re1, id_re2, ex_ld, br_take;
  logic [4:0]  id_ra1, id_ra2, ex_wa;
  logic [31:0] br_pc;
  logic [5:0]  stall;
  logic        flush, pc_we;
  logic [31:0] pc_nxt;
  logic [1:0]  state;
`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: spec state number, pending redirect (0 or 1 entries), stall count.
  int          m_state;
  logic [31:0] m_pend_q[$];
  logic [31:0] m_cnt;

  logic [5:0]  obs_stall;
  logic        obs_flush, obs_pc_we;
  logic [31:0] obs_pc_nxt;
  logic [1:0]  obs_state;
  logic [31:0] obs_cnt;

  pipe_ctrl dut (
    .clk(clk), .rst(rst), .if_req(if_req), .mm_req(mm_req),
    .id_re1(id_re1), .id_re2(id_re2), .id_ra1(id_ra1), .id_ra2(id_ra2),
    .ex_ld(ex_ld), .ex_wa(ex_wa), .br_take(br_take), .br_pc(br_pc),
    .stall(stall), .flush(flush), .pc_we(pc_we), .pc_nxt(pc_nxt),
    .state(state)
`ifdef PIPE_CTRL_PERF_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_hazard();
    logic [4:0] src[2];
    bit         rd[2];
    if (!ex_ld || ex_wa == 5'd0) return 1'b0;
    src[0] = id_ra1; rd[0] = id_re1;
    src[1] = id_ra2; rd[1] = id_re2;
    for (int i = 0; i < 2; i++)
      if (rd[i] && src[i] == ex_wa) return 1'b1;
    return 1'b0;
  endfunction

  task automatic idle_inputs();
    rst = 1'b1; if_req = 1'b0; mm_req = 1'b0; id_re1 = 1'b0; id_re2 = 1'b0;
    id_ra1 = 5'd0; id_ra2 = 5'd0; ex_ld = 1'b0; ex_wa = 5'd0; br_take = 1'b0;
    br_pc = 32'h0;
  endtask

  // One clock cycle: predict, compare mid-cycle, then advance the model past the edge.
  task automatic step();
    logic [5:0]  e_stall;
    logic        e_flush, e_pc_we;
    logic [31:0] e_pc_nxt, n_cnt;
    int          n_state;
    logic [31:0] nq[$];
    @(negedge clk);
    e_stall = 6'd0; e_flush = 1'b0; e_pc_we = 1'b0; e_pc_nxt = 32'h0;
    n_state = S_RUN;
    nq = m_pend_q;
    if (!rst) begin
      nq.delete();
    end else if (mm_req) begin
      e_stall = 6'b011111;
      n_state = S_MEMW;
      if (br_take) begin
        nq.delete();
        nq.push_back(br_pc);
      end
    end else if (nq.size() != 0) begin
      e_pc_we = 1'b1; e_pc_nxt = nq[0]; e_flush = 1'b1;
      nq.delete();
      n_state = S_REDIR;
    end else if (br_take) begin
      e_pc_we = 1'b1; e_pc_nxt = br_pc; e_flush = 1'b1;
      n_state = S_REDIR;
    end else if (m_state == S_REDIR) begin
      e_flush = 1'b1;
    end else if (model_hazard()) begin
      e_stall = 6'b000111;
      n_state = S_LDUSE;
    end else if (if_req) begin
      e_stall = 6'b000011;
    end
    n_cnt = !rst ? 32'd0 : m_cnt + {31'd0, e_stall[0]};

    check("stall",  32'(stall),  32'(e_stall));
    check("flush",  32'(flush),  32'(e_flush));
    check("pc_we",  32'(pc_we),  32'(e_pc_we));
    check("pc_nxt", pc_nxt,      e_pc_nxt);
    check("state",  32'(state),  32'(m_state));
`ifdef PIPE_CTRL_PERF_CNT_EN
    check("stall_cnt", stall_cnt, m_cnt);
    obs_cnt = stall_cnt;
`else
    obs_cnt = m_cnt;
`endif
    obs_stall = stall; obs_flush = flush; obs_pc_we = pc_we;
    obs_pc_nxt = pc_nxt; obs_state = state;

    @(posedge clk);
    #1;
    m_state  = n_state;
    m_pend_q = nq;
    m_cnt    = n_cnt;
  endtask

  initial begin
    idle_inputs();
    m_state = S_RUN; m_cnt = 32'd0;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Reset dominates even with every request asserted.
    mm_req = 1'b1; br_take = 1'b1; if_req = 1'b1; br_pc = 32'hDEAD_BEEF;
    step();
    check("rst_stall", 32'(obs_stall), 32'd0);
    check("rst_pc_we", 32'(obs_pc_we), 32'd0);
    idle_inputs();
    step();
    check("rst_state", 32'(obs_state), 32'(S_RUN));

    // Single load-use hazard gives exactly one stall cycle.
    ex_ld = 1'b1; ex_wa = 5'd5; id_re1 = 1'b1; id_ra1 = 5'd5;
    step();
    check("lu_stall", 32'(obs_stall), 32'b000111);
    idle_inputs();
    step();
    check("lu_state", 32'(obs_state), 32'(S_LDUSE));
    check("lu_after", 32'(obs_stall), 32'd0);

    // Destination x0 is never a hazard.
    ex_ld = 1'b1; ex_wa = 5'd0; id_re1 = 1'b1; id_ra1 = 5'd0;
    step();
    check("x0_stall", 32'(obs_stall), 32'd0);
    idle_inputs();
    step();
    check("x0_state", 32'(obs_state), 32'(S_RUN));

    // Taken branch redirects immediately, then one REDIR flush cycle.
    br_take = 1'b1; br_pc = 32'h0000_1000;
    step();
    check("br_pc_we", 32'(obs_pc_we), 32'd1);
    check("br_pc_nxt", obs_pc_nxt, 32'h0000_1000);
    check("br_flush", 32'(obs_flush), 32'd1);
    idle_inputs();
    if_req = 1'b1;
    step();
    check("redir_state", 32'(obs_state), 32'(S_REDIR));
    check("redir_flush", 32'(obs_flush), 32'd1);
    check("redir_pc_we", 32'(obs_pc_we), 32'd0);
    check("redir_stall", 32'(obs_stall), 32'd0);
    idle_inputs();
    step();
    check("redir_done", 32'(obs_state), 32'(S_RUN));

    // Branch during memory wait is deferred until mm_req drops.
    for (int c = 1; c <= 3; c++) begin
      mm_req = 1'b1; br_take = (c == 2); br_pc = (c == 2) ? 32'h200 : 32'h0;
      step();
      check("mw_stall", 32'(obs_stall), 32'b011111);
      check("mw_pc_we", 32'(obs_pc_we), 32'd0);
    end
    idle_inputs();
    step();
    check("mw_redir_we", 32'(obs_pc_we), 32'd1);
    check("mw_redir_pc", obs_pc_nxt, 32'h200);
    check("mw_redir_fl", 32'(obs_flush), 32'd1);
    step();

    // Reset during MEMW discards the pending redirect.
    mm_req = 1'b1; br_take = 1'b1; br_pc = 32'h40;
    step();
    br_take = 1'b0; rst = 1'b0;
    step();
    idle_inputs();
    step();
    check("rstpend_state", 32'(obs_state), 32'(S_RUN));
    check("rstpend_pc_we", 32'(obs_pc_we), 32'd0);

    // Four memory-stall cycles plus one load-use cycle from a cleared counter.
    rst = 1'b0;
    step();
    idle_inputs();
    for (int c = 0; c < 4; c++) begin
      mm_req = 1'b1;
      step();
    end
    idle_inputs();
    ex_ld = 1'b1; ex_wa = 5'd7; id_re2 = 1'b1; id_ra2 = 5'd7;
    step();
    idle_inputs();
    step();
`ifdef PIPE_CTRL_PERF_CNT_EN
    check("perf_cnt", obs_cnt, 32'd5);
`endif

    // Randomized traffic, small register range to make hazards frequent.
    for (int c = 0; c < 3000; c++) begin
      rst     = ($urandom_range(0, 99) >= 3);
      mm_req  = ($urandom_range(0, 99) < 25);
      br_take = ($urandom_range(0, 99) < 15);
      if_req  = ($urandom_range(0, 99) < 30);
      ex_ld   = ($urandom_range(0, 99) < 50);
      id_re1  = ($urandom_range(0, 99) < 70);
      id_re2  = ($urandom_range(0, 99) < 70);
      ex_wa   = 5'($urandom_range(0, 3));
      id_ra1  = 5'($urandom_range(0, 3));
      id_ra2  = 5'($urandom_range(0, 3));
      br_pc   = $urandom();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
